// File: rtl/stack_engine.sv
// Stack sequencer for PUSH/POP/CALL/RET over a byte-wide memory port.
// Owns the stack pointer, checks bounds at acceptance and moves one byte per memory handshake.
module stack_engine #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    PC_WIDTH    = 10,
  parameter int                    SP_WIDTH    = 8,
  parameter int                    ADDR_WIDTH  = 16,
  parameter logic [SP_WIDTH-1:0]   STACK_START = 8'hBF,
  parameter logic [SP_WIDTH-1:0]   STACK_LIMIT = 8'h40
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [PC_WIDTH-1:0]     cmd_data,
  input  logic                    sp_load,
  input  logic [SP_WIDTH-1:0]     sp_load_value,
  output logic                    rsp_valid,
  output logic [1:0]              rsp_err,
  output logic [PC_WIDTH-1:0]     rsp_data,
  output logic [SP_WIDTH-1:0]     sp,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ack
);

  localparam int PC_BYTES = (PC_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int BUF_W    = PC_BYTES * DATA_WIDTH;
  localparam int SPX_W    = SP_WIDTH + 1;
  localparam logic [2:0]          N_PC   = 3'(PC_BYTES);
  localparam logic [SP_WIDTH-1:0] SP_ONE = SP_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [SP_WIDTH-1:0]   sp_q, sp_d;
  logic                  pop_q, pop_d;
  logic [BUF_W-1:0]      data_buf_q, data_buf_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [1:0]            rsp_err_q, rsp_err_d;
  logic [PC_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [SP_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic [2:0]            n_bytes;
  logic                  is_pop;
  logic [SPX_W-1:0]      sp_ext;
  logic                  push_ok, pop_ok;
  logic [BUF_W-1:0]      buf_load;

  // Bounds use one extra bit so that STACK_LIMIT+N-1 and sp+N never wrap.
  always_comb begin
    n_bytes  = cmd_op[1] ? N_PC : 3'd1;
    is_pop   = cmd_op[0];
    sp_ext   = {1'b0, sp_q};
    push_ok  = sp_ext >= ({1'b0, STACK_LIMIT} + SPX_W'(n_bytes) - SPX_W'(1));
    pop_ok   = (sp_ext + SPX_W'(n_bytes)) <= {1'b0, STACK_START};
    buf_load = cmd_op[1] ? BUF_W'(cmd_data) : BUF_W'(cmd_data[DATA_WIDTH-1:0]);
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    pop_d      = pop_q;
    data_buf_d = data_buf_q;
    cnt_d      = cnt_q;
    rsp_err_d  = rsp_err_q;
    rsp_data_d = rsp_data_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (sp_load) begin
          sp_d = sp_load_value;
        end else if (cmd_valid) begin
          if (is_pop ? pop_ok : push_ok) begin
            state_d    = S_XFER;
            pop_d      = is_pop;
            cnt_d      = n_bytes;
            data_buf_d = is_pop ? '0 : buf_load;
            mem_req_d  = 1'b1;
            mem_we_d   = !is_pop;
            addr_d     = is_pop ? sp_q + SP_ONE : sp_q;
            wdata_d    = is_pop ? '0 : buf_load[DATA_WIDTH-1:0];
          end else begin
            state_d    = S_DONE;
            rsp_err_d  = is_pop ? 2'b10 : 2'b01;
            rsp_data_d = '0;
          end
        end
      end

      S_XFER: begin
        if (mem_ack) begin
          cnt_d = cnt_q - 3'd1;
          // Pops shift bytes in MSB-first; pushes shift the LSB out first.
          if (pop_q) begin
            sp_d       = sp_q + SP_ONE;
            data_buf_d = (data_buf_q << DATA_WIDTH) | BUF_W'(mem_rdata);
          end else begin
            sp_d       = sp_q - SP_ONE;
            data_buf_d = data_buf_q >> DATA_WIDTH;
          end
          if (cnt_q == 3'd1) begin
            state_d    = S_DONE;
            mem_req_d  = 1'b0;
            mem_we_d   = 1'b0;
            rsp_err_d  = 2'b00;
            rsp_data_d = pop_q ? data_buf_d[PC_WIDTH-1:0] : '0;
          end else begin
            addr_d  = pop_q ? sp_d + SP_ONE : sp_d;
            wdata_d = data_buf_d[DATA_WIDTH-1:0];
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      sp_q       <= STACK_START;
      pop_q      <= 1'b0;
      data_buf_q <= '0;
      cnt_q      <= '0;
      rsp_err_q  <= '0;
      rsp_data_q <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      pop_q      <= pop_d;
      data_buf_q <= data_buf_d;
      cnt_q      <= cnt_d;
      rsp_err_q  <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE) && !sp_load;
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign sp        = sp_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = ADDR_WIDTH'(addr_q);
  assign mem_wdata = wdata_q;

endmodule
